// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce_bank chatter filter.
package debounce_pkg;

  localparam int unsigned DEB_SAMPLE_DIV = 32;
  localparam int unsigned DEB_STABLE_N   = 4;
  localparam int unsigned SYNC_STAGES    = 2;

  // $clog2 that never yields a zero-width vector.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounce channel: synchroniser, stability counter, level and edge pulses.
// Optional toggle latch built only when DEBOUNCE_TOGGLE_EN is defined.
module debounce_cell
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_N    = DEB_STABLE_N,
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic in_bit,
  input  logic sample_tick,
  output logic out,
  output logic rise,
  output logic fall
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic tog
`endif
);

  localparam int unsigned CntW = clog2_min1(STABLE_N + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sample_tick) begin
      // A single sample matching the current level cancels any pending change.
      if (s == out_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(STABLE_N - 1)) begin
        out_d  = s;
        cnt_d  = '0;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q  <= '0;
      out_q  <= RESET_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DEBOUNCE_TOGGLE_EN
  logic tog_q, tog_d;

  // Flip on the same edge that raises rise, so the two are coincident.
  always_comb tog_d = tog_q ^ rise_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= tog_d;
    end
  end

  assign tog = tog_q;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debounce filter: shared sample prescaler feeding CH debounce cells.
// Define DEBOUNCE_TOGGLE_EN to add the per-channel tog output.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned SAMPLE_DIV  = DEB_SAMPLE_DIV,
  parameter int unsigned STABLE_N    = DEB_STABLE_N,
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          sample_tick
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic [CH-1:0] tog
`endif
);

  localparam int unsigned PreW = clog2_min1(SAMPLE_DIV);

  logic [PreW-1:0] pre_q, pre_d;
  logic            tick_q, tick_d;
  logic            pre_wrap;

  // With SAMPLE_DIV == 1 the counter sits at 0 and wraps every clock.
  assign pre_wrap = (pre_q == PreW'(SAMPLE_DIV - 1));

  always_comb begin
    pre_d  = pre_wrap ? '0 : pre_q + PreW'(1);
    tick_d = pre_wrap;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign sample_tick = tick_q;

  for (genvar i = 0; i < CH; i++) begin : g_cell
    debounce_cell #(
      .STABLE_N   (STABLE_N),
      .RESET_LEVEL(RESET_LEVEL)
    ) u_cell (
      .clock      (clock),
      .reset      (reset),
      .in_bit     (in[i]),
      .sample_tick(tick_q),
      .out        (out[i]),
      .rise       (rise[i]),
      .fall       (fall[i])
`ifdef DEBOUNCE_TOGGLE_EN
      ,
      .tog        (tog[i])
`endif
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: default build (4ch, /32, N=4) plus a
// 2ch, SAMPLE_DIV=1, STABLE_N=1 instance, both against a sample-history model.
module tb_debounce_bank;

  localparam int NM = 2;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_a  = 4'hF;
  logic [1:0] in_b  = 2'b00;
  logic [3:0] out_a, rise_a, fall_a;
  logic [1:0] out_b, rise_b, fall_b;
  logic       tick_a, tick_b;
`ifdef DEBOUNCE_TOGGLE_EN
  logic [3:0] tog_a;
  logic [1:0] tog_b;
  logic [3:0] m_tog[NM];
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  debounce_bank #(
    .CH(4), .SAMPLE_DIV(32), .STABLE_N(4), .RESET_LEVEL(1'b0)
  ) u_dut_a (
    .clock      (clock),
    .reset      (rst_n),
    .in         (in_a),
    .out        (out_a),
    .rise       (rise_a),
    .fall       (fall_a),
    .sample_tick(tick_a)
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    .tog        (tog_a)
`endif
  );

  debounce_bank #(
    .CH(2), .SAMPLE_DIV(1), .STABLE_N(1), .RESET_LEVEL(1'b0)
  ) u_dut_b (
    .clock      (clock),
    .reset      (rst_n),
    .in         (in_b),
    .out        (out_b),
    .rise       (rise_b),
    .fall       (fall_b),
    .sample_tick(tick_b)
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    .tog        (tog_b)
`endif
  );

  // Reference model: raw input history delayed two clocks, a per-channel record
  // of samples taken since the last level change, and the output level.
  int unsigned mdiv[NM] = '{32, 1};
  int unsigned mn[NM]   = '{4, 1};
  int unsigned mch[NM]  = '{4, 2};
  logic [3:0]  m_out[NM], m_rise[NM], m_fall[NM], p1[NM], p2[NM];
  logic        m_tick[NM];
  logic [31:0] hist[NM][4];
  int unsigned nsamp[NM][4];
  int unsigned edge_n;

  task automatic model_reset();
    edge_n = 0;
    for (int d = 0; d < NM; d++) begin
      m_out[d] = '0; m_rise[d] = '0; m_fall[d] = '0;
      p1[d] = '0; p2[d] = '0; m_tick[d] = 1'b0;
`ifdef DEBOUNCE_TOGGLE_EN
      m_tog[d] = '0;
`endif
      for (int c = 0; c < 4; c++) begin
        hist[d][c]  = '0;
        nsamp[d][c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    logic [3:0]  cur;
    logic [3:0]  s;
    logic [31:0] mask;
    bit          samp;
    edge_n++;
    for (int d = 0; d < NM; d++) begin
      cur  = (d == 0) ? in_a : {2'b00, in_b};
      s    = p2[d];
      samp = (edge_n >= 2) && (((edge_n - 1) % mdiv[d]) == 0);
      mask = (32'd1 << mn[d]) - 32'd1;
      m_rise[d] = '0;
      m_fall[d] = '0;
      for (int c = 0; c < mch[d]; c++) begin
        if (samp) begin
          hist[d][c] = {hist[d][c][30:0], s[c]};
          nsamp[d][c]++;
          if (nsamp[d][c] >= mn[d] &&
              (hist[d][c] & mask) == (m_out[d][c] ? 32'd0 : mask)) begin
            m_out[d][c]  = ~m_out[d][c];
            m_rise[d][c] = m_out[d][c];
            m_fall[d][c] = ~m_out[d][c];
            nsamp[d][c]  = 0;
          end
        end
      end
`ifdef DEBOUNCE_TOGGLE_EN
      m_tog[d] = m_tog[d] ^ m_rise[d];
`endif
      p2[d] = p1[d];
      p1[d] = cur;
      m_tick[d] = ((edge_n % mdiv[d]) == 0);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_out", 32'(out_a), 32'(m_out[0]));
    chk("a_rise", 32'(rise_a), 32'(m_rise[0]));
    chk("a_fall", 32'(fall_a), 32'(m_fall[0]));
    chk("a_tick", 32'(tick_a), 32'(m_tick[0]));
    chk("b_out", 32'(out_b), 32'(m_out[1][1:0]));
    chk("b_rise", 32'(rise_b), 32'(m_rise[1][1:0]));
    chk("b_fall", 32'(fall_b), 32'(m_fall[1][1:0]));
    chk("b_tick", 32'(tick_b), 32'(m_tick[1]));
`ifdef DEBOUNCE_TOGGLE_EN
    chk("a_tog", 32'(tog_a), 32'(m_tog[0]));
    chk("b_tog", 32'(tog_b), 32'(m_tog[1][1:0]));
`endif
  endtask

  // One clock: fresh random input for the DIV=1 instance, model step, compare.
  task automatic cycle();
    in_b = 2'($urandom_range(0, 3));
    @(posedge clock);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int cnt;
    int lat;
    model_reset();

    // 1. Reset with inputs high, then a single clean rise on all channels.
    repeat (3) cycle();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (rise_a == 4'hF) cnt++;
    end
    chk("t1_rise_once", 32'(cnt), 32'd1);
    chk("t1_out_high", 32'(out_a), 32'hF);

    in_a = 4'h0;
    repeat (200) cycle();
    chk("t1_out_low", 32'(out_a), 32'h0);

    // 2. Chatter on ch0 with a 40-clock period never reaches four agreeing samples.
    cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      if (k % 20 == 0) in_a[0] = ~in_a[0];
      cycle();
      if (rise_a[0]) cnt++;
    end
    chk("t2_no_rise", 32'(cnt), 32'd0);
    chk("t2_out0_low", 32'(out_a[0]), 32'd0);
    in_a[0] = 1'b0;
    repeat (200) cycle();

    // 3. Step latency on ch1, aligned so the first post-sync sample is immediate.
    for (int dir = 1; dir >= 0; dir--) begin
      for (int k = 0; k < 40 && !tick_a; k++) cycle();
      repeat (30) cycle();
      in_a[1] = dir[0];
      lat = 140;
      for (int k = 0; k < 140; k++) begin
        cycle();
        if (out_a[1] == dir[0]) begin
          lat = k;
          break;
        end
      end
      chk(dir ? "t3_rise_latency" : "t3_fall_latency", 32'(lat), 32'd98);
      repeat (40) cycle();
    end

    // 4. Three high samples, one low, then four high: exactly one rise on ch2.
    cnt = 0;
    in_a[2] = 1'b1;
    for (int k = 0; k < 96; k++) begin cycle(); if (rise_a[2]) cnt++; end
    in_a[2] = 1'b0;
    for (int k = 0; k < 32; k++) begin cycle(); if (rise_a[2]) cnt++; end
    chk("t4_no_early_rise", 32'(out_a[2]), 32'd0);
    in_a[2] = 1'b1;
    for (int k = 0; k < 200; k++) begin cycle(); if (rise_a[2]) cnt++; end
    chk("t4_one_rise", 32'(cnt), 32'd1);
    chk("t4_out2_high", 32'(out_a[2]), 32'd1);

    // 5. Reset in the middle of a pending change on ch3: nothing after release.
    in_a = 4'h8;
    repeat (70) cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    in_a = 4'h0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if ((rise_a | fall_a) != 4'h0) cnt++;
    end
    chk("t5_no_pulse", 32'(cnt), 32'd0);

    // 6. Three clean presses on ch3.
    cnt = 0;
    for (int p = 0; p < 3; p++) begin
      in_a[3] = 1'b1;
      for (int k = 0; k < 200; k++) begin cycle(); if (rise_a[3]) cnt++; end
      in_a[3] = 1'b0;
      for (int k = 0; k < 200; k++) cycle();
    end
    chk("t6_three_rises", 32'(cnt), 32'd3);
`ifdef DEBOUNCE_TOGGLE_EN
    chk("t6_tog3_final", 32'(tog_a[3]), 32'd1);
`endif

    // Random segments of random length on all channels.
    for (int seg = 0; seg < 14; seg++) begin
      in_a = 4'($urandom);
      cnt  = $urandom_range(1, 200);
      for (int k = 0; k < cnt; k++) cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
